// File: rtl/btn_event_decoder.sv
// btn_event_decoder
//   Classifies presses of a debounced button into exactly one event each:
//   short press, long press or double press. Each event is a one-clock
//   pulse. Durations are measured in prescaler ticks (one tick every
//   2^TICK_BITS clocks), and the tick phase is free-running.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   db           debounced switch level, synchronous to clk
//   short_pulse  one-cycle pulse: short press detected
//   long_pulse   one-cycle pulse: long-press threshold reached
//   double_pulse one-cycle pulse: second press started inside the gap window
//   held         level, high while a long press remains held
//   busy         high whenever the FSM is not in IDLE
//
// All outputs are registered. Each pulse appears on the clock after the
// cycle in which its transition is taken.
module btn_event_decoder #(
  parameter int TICK_BITS  = 20,
  parameter int CNT_W      = 8,
  parameter int LONG_TICKS = 50,
  parameter int DBL_TICKS  = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    S_LOCKOUT   = 3'd0,
    S_IDLE      = 3'd1,
    S_PRESSED   = 3'd2,
    S_LONG_HELD = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  // Count values at which the next tick completes the threshold.
  localparam logic [CNT_W-1:0] DUR_MAX   = '1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);

  state_t               state;
  logic [TICK_BITS-1:0] prescaler;
  logic [CNT_W-1:0]     dur;
  logic                 tick;

  assign tick = (prescaler == '0);

  // Free-running prescaler; never realigned to presses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + TICK_BITS'(1);
    end
  end

  // FSM, duration counter and registered outputs. The duration counter
  // counts ticks while the state is unchanged and is cleared by every
  // transition branch below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_LOCKOUT;
      dur          <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      held         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      held         <= 1'b0;
      busy         <= 1'b1;
      if (tick && (dur != DUR_MAX)) begin
        dur <= dur + CNT_W'(1);
      end

      case (state)
        S_LOCKOUT: begin
          // Waits out a press that must not produce further events.
          if (!db) begin
            state <= S_IDLE;
            dur   <= '0;
            busy  <= 1'b0;
          end
        end

        S_IDLE: begin
          if (db) begin
            state <= S_PRESSED;
            dur   <= '0;
          end else begin
            busy <= 1'b0;
          end
        end

        S_PRESSED: begin
          // Release has priority over a coincident threshold tick.
          if (!db) begin
            state <= S_GAP;
            dur   <= '0;
          end else if (tick && (dur == LONG_LAST)) begin
            state      <= S_LONG_HELD;
            dur        <= '0;
            long_pulse <= 1'b1;
            held       <= 1'b1;
          end
        end

        S_LONG_HELD: begin
          if (!db) begin
            state <= S_IDLE;
            dur   <= '0;
            busy  <= 1'b0;
          end else begin
            held <= 1'b1;
          end
        end

        S_GAP: begin
          // A new press has priority over a coincident expiry tick.
          if (db) begin
            state        <= S_LOCKOUT;
            dur          <= '0;
            double_pulse <= 1'b1;
          end else if (tick && (dur == DBL_LAST)) begin
            state       <= S_IDLE;
            dur         <= '0;
            short_pulse <= 1'b1;
            busy        <= 1'b0;
          end
        end

        default: begin
          state <= S_LOCKOUT;
          dur   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder
//   Directed bench for btn_event_decoder with TICK_BITS=2 (tick every
//   4 clocks), CNT_W=4, LONG_TICKS=4, DBL_TICKS=3. A per-cycle vector table
//   covers short, long and double presses from reset; hand-written
//   sequences cover reset with the button held, coincident tick/edge
//   cases and reset while a short press is pending.
module tb_btn_event_decoder;

  logic clk;
  logic reset;
  logic db;
  logic short_pulse;
  logic long_pulse;
  logic double_pulse;
  logic held;
  logic busy;

  btn_event_decoder #(
    .TICK_BITS (2),
    .CNT_W     (4),
    .LONG_TICKS(4),
    .DBL_TICKS (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db          (db),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .double_pulse(double_pulse),
    .held        (held),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total  = 0;
  int passed = 0;
  int cyc    = 0;   // index of the next clock edge since reset release
  int n_short, n_long, n_dbl;
  int last_short, last_long, last_dbl;

  typedef struct {
    logic db;
    logic s;
    logic l;
    logic d;
    logic h;
    logic b;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end else begin
      passed++;
    end
  endtask

  task automatic clear_tally();
    n_short = 0; n_long = 0; n_dbl = 0;
    last_short = -1; last_long = -1; last_dbl = -1;
  endtask

  // One clock edge; outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (short_pulse)  begin n_short++; last_short = cyc; end
    if (long_pulse)   begin n_long++;  last_long  = cyc; end
    if (double_pulse) begin n_dbl++;   last_dbl   = cyc; end
    chk("exclusive", 32'(($countones({short_pulse, long_pulse, double_pulse}) <= 1)), 32'd1);
    cyc++;
  endtask

  task automatic drive(input logic d, input int n);
    db = d;
    for (int i = 0; i < n; i++) step();
  endtask

  // Step with db=0 until the next edge index has the given tick phase.
  task automatic align(input int ph);
    db = 1'b0;
    while ((cyc % 4) != ph) step();
  endtask

  task automatic add(input int n, input logic d, input logic s, input logic l,
                     input logic dd, input logic h, input logic b);
    vec_t v;
    v.db = d; v.s = s; v.l = l; v.d = dd; v.h = h; v.b = b;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check_outs_zero(input string tag);
    chk({tag, " short"},  32'(short_pulse),  32'd0);
    chk({tag, " long"},   32'(long_pulse),   32'd0);
    chk({tag, " double"}, 32'(double_pulse), 32'd0);
    chk({tag, " held"},   32'(held),         32'd0);
    chk({tag, " busy"},   32'(busy),         32'd0);
  endtask

  // Safety net against a stuck run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus / scoreboard ----------------
  initial begin
    int e;
    int g;
    int exp_edge;
    int nt;

    // Per-cycle table: db driven before edge i, outputs expected after it.
    // Short press: rise at edge 1, fall at edge 7, short at edge 16.
    add(1,  0, 0, 0, 0, 0, 0);
    add(6,  1, 0, 0, 0, 0, 1);
    add(9,  0, 0, 0, 0, 0, 1);
    add(1,  0, 1, 0, 0, 0, 0);
    add(3,  0, 0, 0, 0, 0, 0);
    // Long press: rise at edge 20, long at edge 36, fall at edge 50.
    add(16, 1, 0, 0, 0, 0, 1);
    add(1,  1, 0, 1, 0, 1, 1);
    add(13, 1, 0, 0, 0, 1, 1);
    add(4,  0, 0, 0, 0, 0, 0);
    // Double press: rise 54, fall 59, rise 63 (double), fall 68.
    add(5,  1, 0, 0, 0, 0, 1);
    add(4,  0, 0, 0, 0, 0, 1);
    add(1,  1, 0, 0, 1, 0, 1);
    add(4,  1, 0, 0, 0, 0, 1);
    add(4,  0, 0, 0, 0, 0, 0);

    db    = 1'b0;
    reset = 1'b1;
    clear_tally();
    #1;
    check_outs_zero("reset_init");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs_zero("reset_held");
    reset = 1'b0;
    cyc   = 0;

    foreach (vecs[i]) begin
      db = vecs[i].db;
      step();
      chk($sformatf("vec%0d short",  i), 32'(short_pulse),  32'(vecs[i].s));
      chk($sformatf("vec%0d long",   i), 32'(long_pulse),   32'(vecs[i].l));
      chk($sformatf("vec%0d double", i), 32'(double_pulse), 32'(vecs[i].d));
      chk($sformatf("vec%0d held",   i), 32'(held),         32'(vecs[i].h));
      chk($sformatf("vec%0d busy",   i), 32'(busy),         32'(vecs[i].b));
    end

    // ---- Reset with the button held: lockout until release ----
    db    = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outs_zero("lock_reset");
    reset = 1'b0;
    cyc   = 0;
    clear_tally();
    for (int i = 0; i < 40; i++) begin
      step();
      chk("lock busy", 32'(busy), 32'd1);
    end
    chk("lock pulses", 32'(n_short + n_long + n_dbl), 32'd0);
    drive(1'b0, 1);
    chk("lock release busy", 32'(busy), 32'd0);
    drive(1'b1, 6);
    drive(1'b0, 20);
    chk("lock then short n_short", 32'(n_short), 32'd1);
    chk("lock then short others",  32'(n_long + n_dbl), 32'd0);

    // ---- Release on the exact cycle of the 4th tick in PRESSED ----
    clear_tally();
    align(1);
    e = cyc;                 // PRESSED entered at edge e; ticks e+3,7,11,15
    drive(1'b1, 15);
    chk("pre_release held", 32'(held), 32'd0);
    drive(1'b0, 20);
    chk("coinc_rel n_long",  32'(n_long),     32'd0);
    chk("coinc_rel n_short", 32'(n_short),    32'd1);
    chk("coinc_rel edge",    32'(last_short), 32'(e + 27));
    chk("coinc_rel n_dbl",   32'(n_dbl),      32'd0);

    // ---- Press on the exact cycle of the GAP expiry tick ----
    clear_tally();
    align(1);
    drive(1'b1, 6);
    g = cyc;                 // GAP entered at this edge
    exp_edge = g;
    nt = 0;
    while (nt < 3) begin
      exp_edge++;
      if ((exp_edge % 4) == 0) nt++;
    end
    drive(1'b0, exp_edge - g);
    drive(1'b1, 1);
    chk("coinc_press n_dbl", 32'(n_dbl),    32'd1);
    chk("coinc_press edge",  32'(last_dbl), 32'(exp_edge));
    // Second press held well past the long threshold: no long event.
    drive(1'b1, 25);
    chk("dbl_hold held", 32'(held), 32'd0);
    chk("dbl_hold busy", 32'(busy), 32'd1);
    drive(1'b0, 1);
    chk("dbl_release busy", 32'(busy), 32'd0);
    drive(1'b0, 15);
    chk("coinc_press n_short", 32'(n_short), 32'd0);
    chk("coinc_press n_long",  32'(n_long),  32'd0);

    // ---- Reset while a short press is pending in GAP ----
    clear_tally();
    drive(1'b1, 6);
    drive(1'b0, 2);
    chk("gap busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_outs_zero("gap_async_reset");
    @(posedge clk);
    #1;
    check_outs_zero("gap_reset_cycle");
    reset = 1'b0;
    cyc   = 0;
    drive(1'b0, 20);
    chk("gap_reset pulses", 32'(n_short + n_long + n_dbl), 32'd0);
    chk("gap_reset busy",   32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
